// File: rtl/pwm_sample_decoder.sv
// pwm_sample_decoder
//   Recovers 8-bit audio samples from a 1-bit PWM stream. After locking onto a
//   rising edge of the synchronized input, the block counts high cycles over
//   consecutive FRAME_LEN-cycle frames. It scales each count to 8 bits,
//   saturates it at 255 and queues the result in a small output FIFO.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   ena         decode enable; low forces IDLE and drops any partial frame
//   pwm_in      asynchronous PWM input
//   m_data      sample at the FIFO head (0 while empty)
//   m_valid     FIFO not empty
//   m_ready     consumer accepts m_data (pop when m_valid && m_ready)
//   locked      frame alignment acquired (state MEASURE)
//   overflow    sticky: a sample was dropped because the FIFO was full
//   frame_count completed frames, wraps at 16 bits
module pwm_sample_decoder #(
    parameter int unsigned FRAME_LEN  = 256,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        pwm_in,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        locked,
    output logic        overflow,
    output logic [15:0] frame_count
);

    localparam int unsigned CW = $clog2(FRAME_LEN);
    localparam int unsigned HW = CW + 1;
    localparam int unsigned SH = 8 - CW;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SYNC    = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;

    logic [1:0]    state;
    logic          sync1;
    logic          pwm_s;
    logic          pwm_prev;
    logic [CW-1:0] pos;
    logic [HW-1:0] high;

    logic          last;
    logic          push;
    logic          pop;
    logic [HW-1:0] total;
    logic [8:0]    scaled;
    logic [7:0]    sample;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;

    // Input synchronizer and one-cycle history for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            pwm_s    <= 1'b0;
            pwm_prev <= 1'b0;
        end else begin
            sync1    <= pwm_in;
            pwm_s    <= sync1;
            pwm_prev <= pwm_s;
        end
    end

    // The final frame cycle still contributes its own pwm_s level to the sample
    always_comb begin
        last   = (pos == CW'(FRAME_LEN - 1));
        push   = ena && (state == MEASURE) && last;
        total  = high + HW'(pwm_s);
        scaled = 9'(total) << SH;
        sample = scaled[8] ? 8'hFF : scaled[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pos   <= '0;
            high  <= '0;
        end else if (!ena) begin
            state <= IDLE;
            pos   <= '0;
            high  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= SYNC;
                end
                SYNC: begin
                    // The edge cycle itself is frame cycle 0 and is high
                    if (pwm_s && !pwm_prev) begin
                        state <= MEASURE;
                        pos   <= CW'(1);
                        high  <= HW'(1);
                    end
                end
                MEASURE: begin
                    // Frames run back to back; no re-sync on the next edge
                    if (last) begin
                        pos  <= '0;
                        high <= '0;
                    end else begin
                        pos  <= pos + CW'(1);
                        high <= total;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
        end else if (push) begin
            frame_count <= frame_count + 16'd1;
        end
    end

    // Output FIFO: pointers carry one extra wrap bit for full/empty detection
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop   = !empty && m_ready;
    end

    always_ff @(posedge clk) begin
        if (push && (!full || pop)) begin
            mem[wr_ptr[AW-1:0]] <= sample;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push && (!full || pop)) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign m_valid = !empty;
    assign m_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    assign locked  = (state == MEASURE);

endmodule

// File: tb/tb_pwm_sample_decoder.sv
module tb_pwm_sample_decoder;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        pwm_in;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        locked;
    logic        overflow;
    logic [15:0] frame_count;

    logic        ena2;
    logic        pwm2;
    logic [7:0]  m_data2;
    logic        m_valid2;
    logic        m_ready2;
    logic        locked2;
    logic        overflow2;
    logic [15:0] frame_count2;

    int checks;
    int errors;
    int phase;
    logic [7:0] got [$];

    pwm_sample_decoder #(.FRAME_LEN(256), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .ena(ena), .pwm_in(pwm_in),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .locked(locked), .overflow(overflow), .frame_count(frame_count)
    );

    pwm_sample_decoder #(.FRAME_LEN(16), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .ena(ena2), .pwm_in(pwm2),
        .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready2),
        .locked(locked2), .overflow(overflow2), .frame_count(frame_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; a handshake seen now is the pop the coming posedge performs
    task automatic step();
        if (m_valid && m_ready) got.push_back(m_data);
        @(negedge clk);
    endtask

    task automatic pwm_run(input int n, input int hi);
        for (int i = 0; i < n; i++) begin
            pwm_in = (phase < hi);
            phase  = (phase + 1) % 256;
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pwm_in = 1'b0;
        step();
        step();
        rst = 1'b0;
        phase = 0;
        got.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        phase  = 0;
        rst = 1'b0; ena = 1'b0; pwm_in = 1'b0; m_ready = 1'b0;
        ena2 = 1'b1; pwm2 = 1'b0; m_ready2 = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_locked", locked, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_count", frame_count, 0);

        // Duty 64/256, locking latency and samples
        ena = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("sync_not_locked", locked, 0);
        pwm_run(2, 64);
        check("lock_cycle2", locked, 0);
        pwm_run(1, 64);
        check("lock_cycle3", locked, 1);
        pwm_run(797, 64);
        check("d64_count", got.size(), 3);
        for (int i = 0; i < 3; i++) check("d64_sample", (got.size() > i) ? got[i] : 8'hxx, 8'h40);
        check("d64_frame_count", frame_count, 3);

        // Constant high saturates
        do_reset();
        for (int i = 0; i < 3; i++) step();
        pwm_run(300, 256);
        check("sat_frame_count1", frame_count, 1);
        check("sat_count", got.size(), 1);
        check("sat_sample", (got.size() > 0) ? got[0] : 8'hxx, 8'hFF);
        pwm_run(256, 256);
        check("sat_frame_count2", frame_count, 2);

        // Consumer stalled for six frames
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        pwm_run(1100, 128);
        check("stall_fc4", frame_count, 4);
        check("stall_valid", m_valid, 1);
        check("stall_head", m_data, 8'h80);
        check("stall_ovf_before", overflow, 0);
        pwm_run(200, 128);
        check("stall_fc5", frame_count, 5);
        check("stall_ovf_after5", overflow, 1);
        check("stall_head_held", m_data, 8'h80);
        pwm_run(260, 128);
        check("stall_fc6", frame_count, 6);
        m_ready = 1'b1;
        pwm_run(8, 128);
        check("stall_drain_count", got.size(), 4);
        for (int i = 0; i < 4; i++) check("stall_drain_data", (got.size() > i) ? got[i] : 8'hxx, 8'h80);
        check("stall_drained", m_valid, 0);
        check("stall_ovf_sticky", overflow, 1);

        // ena dropped at frame cycle 100 of the second frame
        do_reset();
        check("rst_clears_overflow", overflow, 0);
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        pwm_run(357, 64);
        check("dis_locked_before", locked, 1);
        check("dis_fc_before", frame_count, 1);
        ena = 1'b0;
        pwm_run(1, 64);
        check("dis_unlocked", locked, 0);
        pwm_run(200, 64);
        check("dis_fc_unchanged", frame_count, 1);
        check("dis_retained", m_valid, 1);
        check("dis_retained_data", m_data, 8'h40);
        m_ready = 1'b1;
        pwm_run(3, 64);
        check("dis_drain_count", got.size(), 1);
        check("dis_drained", m_valid, 0);
        ena = 1'b1;
        pwm_in = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("reen_waits_edge", locked, 0);
        phase = 0;
        pwm_run(2, 64);
        check("reen_lock_cycle2", locked, 0);
        pwm_run(1, 64);
        check("reen_lock_cycle3", locked, 1);

        // Full FIFO, push coincides with pop
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        pwm_run(256, 10);
        pwm_run(256, 20);
        pwm_run(256, 30);
        pwm_run(256, 40);
        pwm_run(257, 50);
        check("full_valid", m_valid, 1);
        check("full_head", m_data, 8'h0A);
        check("full_fc", frame_count, 4);
        m_ready = 1'b1;
        pwm_run(1, 50);
        m_ready = 1'b0;
        check("pp_fc", frame_count, 5);
        check("pp_no_overflow", overflow, 0);
        check("pp_head", m_data, 8'h14);
        m_ready = 1'b1;
        pwm_run(6, 50);
        check("pp_count", got.size(), 5);
        for (int i = 0; i < 5; i++) check("pp_order", (got.size() > i) ? got[i] : 8'hxx, 8'((i + 1) * 10));
        check("pp_drained", m_valid, 0);

        // Reset with entries queued while locked
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        pwm_run(800, 64);
        check("pre_rst_locked", locked, 1);
        check("pre_rst_valid", m_valid, 1);
        check("pre_rst_fc", frame_count, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_fc", frame_count, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_data", m_data, 0);

        // FRAME_LEN=16 scaling: 5 high cycles -> 5<<4
        ena = 1'b0;
        for (int i = 0; i < 40; i++) begin
            pwm2 = ((i % 16) < 5);
            @(negedge clk);
        end
        check("f16_fc", frame_count2, 2);
        check("f16_valid", m_valid2, 1);
        check("f16_sample", m_data2, 8'h50);
        check("f16_no_ovf", overflow2, 0);

        // FRAME_LEN=16 constant high: 16<<4 saturates
        pwm2 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        pwm2 = 1'b1;
        for (int i = 0; i < 20; i++) @(negedge clk);
        check("f16_sat_fc", frame_count2, 1);
        check("f16_sat_sample", m_data2, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
